// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: one holding slot per requester,
// oldest-first grant with round-robin tie-break onto a single write port.
module rf_write_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          a_valid,
    input  logic [RW-1:0] a_sel,
    input  logic [DW-1:0] a_dat,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [RW-1:0] b_sel,
    input  logic [DW-1:0] b_dat,
    output logic          b_ready,
    output logic          WEN,
    output logic [RW-1:0] wsel,
    output logic [DW-1:0] wdat,
    output logic [31:0]   pend
);

    typedef enum logic [1:0] {AgeTie, AgeAOlder, AgeBOlder} age_e;

    logic          a_full_q, a_full_d, b_full_q, b_full_d;
    logic [RW-1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic [DW-1:0] a_dat_q, a_dat_d, b_dat_q, b_dat_d;
    age_e          age_q, age_d;
    logic          last_grant_q, last_grant_d;  // 1: B was granted most recently
    logic          gnt_a, gnt_b, a_fill, b_fill;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (a_full_q && b_full_q) begin
            unique case (age_q)
                AgeAOlder: gnt_a = 1'b1;
                AgeBOlder: gnt_b = 1'b1;
                default: begin
                    gnt_a = last_grant_q;
                    gnt_b = !last_grant_q;
                end
            endcase
        end else begin
            gnt_a = a_full_q;
            gnt_b = b_full_q;
        end
        if (RST) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    assign a_ready = !RST && (!a_full_q || gnt_a);
    assign b_ready = !RST && (!b_full_q || gnt_b);
    // Writes to register 0 are accepted but never occupy a slot.
    assign a_fill  = a_valid && a_ready && (a_sel != '0);
    assign b_fill  = b_valid && b_ready && (b_sel != '0);

    always_comb begin
        a_full_d     = a_fill ? 1'b1 : (gnt_a ? 1'b0 : a_full_q);
        b_full_d     = b_fill ? 1'b1 : (gnt_b ? 1'b0 : b_full_q);
        a_sel_d      = a_fill ? a_sel : a_sel_q;
        a_dat_d      = a_fill ? a_dat : a_dat_q;
        b_sel_d      = b_fill ? b_sel : b_sel_q;
        b_dat_d      = b_fill ? b_dat : b_dat_q;
        last_grant_d = gnt_a ? 1'b0 : (gnt_b ? 1'b1 : last_grant_q);
        age_d        = AgeTie;
        if (a_full_d && b_full_d) begin
            if (a_fill && !b_fill)      age_d = AgeBOlder;
            else if (b_fill && !a_fill) age_d = AgeAOlder;
            else if (a_fill && b_fill)  age_d = AgeTie;
            else                        age_d = age_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_full_q     <= 1'b0;
            b_full_q     <= 1'b0;
            a_sel_q      <= '0;
            a_dat_q      <= '0;
            b_sel_q      <= '0;
            b_dat_q      <= '0;
            age_q        <= AgeTie;
            last_grant_q <= 1'b1;
        end else begin
            a_full_q     <= a_full_d;
            b_full_q     <= b_full_d;
            a_sel_q      <= a_sel_d;
            a_dat_q      <= a_dat_d;
            b_sel_q      <= b_sel_d;
            b_dat_q      <= b_dat_d;
            age_q        <= age_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        WEN  = gnt_a || gnt_b;
        wsel = gnt_a ? a_sel_q : (gnt_b ? b_sel_q : '0);
        wdat = gnt_a ? a_dat_q : (gnt_b ? b_dat_q : '0);
        pend = '0;
        if (!RST) begin
            if (a_full_q) pend = pend | (32'd1 << a_sel_q);
            if (b_full_q) pend = pend | (32'd1 << b_sel_q);
            pend[0] = 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter; outputs sampled 1ns after posedge.
module tb_rf_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_valid, b_valid, a_ready, b_ready, WEN;
    logic [4:0]  a_sel, b_sel, wsel;
    logic [31:0] a_dat, b_dat, wdat, pend;
    int          checks = 0;
    int          fails  = 0;

    rf_write_arbiter #(.DW(32), .RW(5)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_sel(a_sel), .a_dat(a_dat), .a_ready(a_ready),
        .b_valid(b_valid), .b_sel(b_sel), .b_dat(b_dat), .b_ready(b_ready),
        .WEN(WEN), .wsel(wsel), .wdat(wdat), .pend(pend)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_sel = '0; a_dat = '0;
        b_valid = 1'b0; b_sel = '0; b_dat = '0;
    endtask

    task automatic apply_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        a_valid = 1'b1; a_sel = 5'd2; a_dat = 32'h5;
        b_valid = 1'b1; b_sel = 5'd3; b_dat = 32'h6;
        tick();
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
        end
        checks++;
        if (WEN !== 1'b0 || wsel !== 5'd0 || wdat !== 32'd0 || pend !== 32'd0) begin
            fails++;
            $display("FAIL reset_out: got wen=%b sel=%0d dat=%h pend=%h want 0 0 0 0",
                     WEN, wsel, wdat, pend);
        end
        idle();
        RST = 1'b0;
        tick();
        checks++;
        if (WEN !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got wen=%b ar=%b br=%b want 0 1 1", WEN, a_ready, b_ready);
        end
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_sel = 5'd3; a_dat = 32'hDEADBEEF;
        tick();
        idle();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd3 || wdat !== 32'hDEADBEEF || pend !== 32'h8) begin
            fails++;
            $display("FAIL single_write: got wen=%b sel=%0d dat=%h pend=%h want 1 3 deadbeef 8",
                     WEN, wsel, wdat, pend);
        end
        tick();
        checks++;
        if (WEN !== 1'b0 || pend !== 32'd0) begin
            fails++; $display("FAIL single_after: got wen=%b pend=%h want 0 0", WEN, pend);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        a_valid = 1'b1; a_sel = 5'd4; a_dat = 32'd1;
        b_valid = 1'b1; b_sel = 5'd5; b_dat = 32'd2;
        tick();
        idle();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd4 || wdat !== 32'd1) begin
            fails++;
            $display("FAIL tie_first: got wen=%b sel=%0d dat=%h want 1 4 1", WEN, wsel, wdat);
        end
        checks++;
        if (b_ready !== 1'b0 || a_ready !== 1'b1 || pend !== 32'h30) begin
            fails++;
            $display("FAIL tie_ready: got br=%b ar=%b pend=%h want 0 1 30", b_ready, a_ready, pend);
        end
        tick();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'd2 || pend !== 32'h20) begin
            fails++;
            $display("FAIL tie_second: got wen=%b sel=%0d dat=%h pend=%h want 1 5 2 20",
                     WEN, wsel, wdat, pend);
        end
        tick();
        checks++;
        if (WEN !== 1'b0) begin
            fails++; $display("FAIL tie_done: got wen=%b want 0", WEN);
        end
    endtask

    task automatic test_ordering();
        apply_reset();
        a_valid = 1'b1; a_sel = 5'd9; a_dat = 32'h99;
        b_valid = 1'b1; b_sel = 5'd7; b_dat = 32'h11;
        tick();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd9 || a_ready !== 1'b1) begin
            fails++;
            $display("FAIL order_first: got wen=%b sel=%0d ar=%b want 1 9 1", WEN, wsel, a_ready);
        end
        b_valid = 1'b0;
        a_sel = 5'd7; a_dat = 32'h22;
        tick();
        idle();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h11 || pend !== 32'h80) begin
            fails++;
            $display("FAIL order_old: got wen=%b sel=%0d dat=%h pend=%h want 1 7 11 80",
                     WEN, wsel, wdat, pend);
        end
        tick();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h22) begin
            fails++;
            $display("FAIL order_young: got wen=%b sel=%0d dat=%h want 1 7 22", WEN, wsel, wdat);
        end
        tick();
        checks++;
        if (WEN !== 1'b0 || pend !== 32'd0) begin
            fails++; $display("FAIL order_done: got wen=%b pend=%h want 0 0", WEN, pend);
        end
    endtask

    task automatic test_zero_reg();
        a_valid = 1'b1; a_sel = 5'd0; a_dat = 32'hFFFFFFFF;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            fails++; $display("FAIL zero_ready_pre: got %b want 1", a_ready);
        end
        tick();
        idle();
        checks++;
        if (WEN !== 1'b0 || pend !== 32'd0 || a_ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_reg: got wen=%b pend=%h ar=%b want 0 0 1", WEN, pend, a_ready);
        end
        tick();
        checks++;
        if (WEN !== 1'b0) begin
            fails++; $display("FAIL zero_reg_later: got wen=%b want 0", WEN);
        end
    endtask

    task automatic test_streaming();
        int wen_cycles = 0;
        for (int i = 1; i <= 8; i++) begin
            a_valid = 1'b1; a_sel = 5'(i); a_dat = 32'(i) * 32'h100;
            #1;
            if (a_ready !== 1'b1) begin
                checks++; fails++;
                $display("FAIL stream_ready_pre %0d: got %b want 1", i, a_ready);
            end
            tick();
            checks++;
            if (WEN !== 1'b1 || wsel !== 5'(i) || wdat !== 32'(i) * 32'h100 || a_ready !== 1'b1)
            begin
                fails++;
                $display("FAIL stream_%0d: got wen=%b sel=%0d dat=%h ar=%b want 1 %0d %h 1",
                         i, WEN, wsel, wdat, a_ready, i, 32'(i) * 32'h100);
            end
            if (WEN === 1'b1) wen_cycles++;
        end
        idle();
        tick();
        checks++;
        if (WEN !== 1'b0 || wen_cycles != 8) begin
            fails++;
            $display("FAIL stream_count: got wen=%b cycles=%0d want 0 8", WEN, wen_cycles);
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_sel = 5'd10; a_dat = 32'hA;
        b_valid = 1'b1; b_sel = 5'd11; b_dat = 32'hB;
        tick();
        idle();
        checks++;
        if (pend !== 32'h0C00 || WEN !== 1'b1) begin
            fails++; $display("FAIL mid_full: got pend=%h wen=%b want c00 1", pend, WEN);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (WEN !== 1'b0 || pend !== 32'd0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_during: got wen=%b pend=%h ar=%b br=%b want 0 0 0 0",
                     WEN, pend, a_ready, b_ready);
        end
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (WEN !== 1'b0 || pend !== 32'd0) begin
                fails++; $display("FAIL mid_after_%0d: got wen=%b pend=%h want 0 0", i, WEN, pend);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        RST = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_ordering();
        test_zero_reg();
        test_streaming();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data word width (matches word_t).
REQ-002 SHALL have parameter RW, default 5, register select width (32 registers).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports a_valid input 1, a_sel input RW, a_dat input DW, a_ready output 1: requester A (ALU writeback) valid/ready write request.
REQ-006 SHALL have ports b_valid input 1, b_sel input RW, b_dat input DW, b_ready output 1: requester B (load writeback) valid/ready write request.
REQ-007 SHALL have ports WEN output 1, wsel output RW, wdat output DW: single register file write port.
REQ-008 SHALL have port pend  output 32  bit r set while any held write targets register r; bit 0 always 0.

Function
REQ-009 SHALL hold one slot per requester (A, B); each slot is EMPTY or FULL, storing sel and dat.
REQ-010 SHALL accept a request on a posedge where x_valid && x_ready, loading slot x to FULL.
REQ-011 SHALL drive x_ready = (slot x EMPTY) || (slot x granted this cycle), allowing back-to-back acceptance.
REQ-012 SHALL treat a request with x_sel == 0 as accepted and discarded: slot stays EMPTY, WEN never asserted for it.
REQ-013 SHALL grant at most one FULL slot per cycle; the granted slot drives WEN=1, wsel, wdat combinationally in that cycle and becomes EMPTY at the next posedge unless refilled per REQ-011.
REQ-014 SHALL drive WEN=0, wsel=0, wdat=0 when no slot is FULL.
REQ-015 SHALL give minimum latency of one cycle: accepted at edge N, WEN visible in cycle after edge N; no combinational valid-to-WEN path.
REQ-016 SHALL keep an age flag: when both slots FULL, the slot filled at an earlier edge is granted first.
REQ-017 SHALL break ties (both slots filled on the same edge) round-robin using a last_grant flop: grant the requester not granted most recently.
REQ-018 SHALL update last_grant on every edge where a grant occurs.
REQ-019 SHALL preserve write order to the same register: two held writes with equal sel SHALL be issued oldest first per REQ-016, so the register ends with the younger data.
REQ-020 SHALL compute pend combinationally from FULL slots only (OR of one-hot decodes of held sel).
REQ-021 SHALL sustain one write per cycle when only one requester is active and a_valid is held high continuously.
REQ-022 SHALL never drop or duplicate an accepted nonzero-sel write; each produces exactly one WEN cycle.

Reset
REQ-023 SHALL, on posedge CLK with RST=1, set both slots EMPTY, clear the age flag, set last_grant=B (so A wins the first tie).
REQ-024 SHALL during RST=1 force a_ready=0, b_ready=0, WEN=0, wsel=0, wdat=0, pend=0; held writes are discarded on reset mid-operation.
REQ-025 SHALL accept requests starting from the first posedge after RST deasserts.

Verification
REQ-026 A only: a_valid=1, a_sel=3, a_dat=0xDEADBEEF at edge N -> WEN=1, wsel=3, wdat=0xDEADBEEF in cycle N+1, pend[3]=1 that cycle, then WEN=0.
REQ-027 Simultaneous fill after reset: A sel=4 dat=1, B sel=5 dat=2 same edge -> WEN to reg 4 first, reg 5 next cycle; b_ready=0 during first cycle.
REQ-028 Ordering: B sel=7 dat=0x11 at edge N while A slot busy; A sel=7 dat=0x22 at edge N+1 -> reg 7 written 0x11 then 0x22.
REQ-029 Zero register: a_sel=0, a_dat=0xFFFFFFFF accepted -> WEN stays 0, pend=0, a_ready stays 1.
REQ-030 Streaming: A valid every cycle with sel 1..8, B idle -> eight consecutive WEN cycles, a_ready never 0.
REQ-031 Reset mid-operation: both slots FULL, RST=1 for one edge -> WEN=0, pend=0, no held write ever issued afterward.
